debounce_edge: RTL and testbench

- Per-bit debounce filter and edge detector for `WIDTH` independent channels.
- Sits directly downstream of the multi-stage synchronizer. It consumes the synchronizer's already-synchronized `dout` and produces a stable, glitch-filtered level per channel plus single-cycle rise/fall pulses.
- Intended for push-buttons, strap pins and slow status lines entering the core clock domain.
- All logic is in one clock domain. No CDC logic inside this block.

---
 rtl/debounce_edge.sv | 92 +++++++++
 tb/tb_debounce_edge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//
// Per-channel debounce filter with registered rise/fall edge pulses.
// Each of WIDTH channels watches its synchronized input and only moves its
// debounced level after the input has differed from that level for Neff
// consecutive clock edges. Neff = thresh, with thresh == 0 treated as 1.
// Any edge at which the input matches the level clears that channel's count,
// so disturbances shorter than Neff cycles never reach the output.
//
// Parameters:
//   WIDTH   - number of independent channels
//   CNT_W   - width of each stability counter and of thresh
//   RST_VAL - reset value of level, one bit per channel
//
// Ports:
//   clk    - core clock, all state updates on its rising edge
//   rst_n  - asynchronous active-low reset
//   din    - synchronized raw inputs (from the upstream synchronizer)
//   thresh - required stable cycle count, shared by all channels
//   level  - debounced level per channel (registered)
//   rise   - one-cycle pulse when level goes 0->1 (registered)
//   fall   - one-cycle pulse when level goes 1->0 (registered)
// -----------------------------------------------------------------------------
module debounce_edge #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      CNT_W   = 16,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic [CNT_W-1:0] thresh,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] level_nxt;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;
   logic [CNT_W-1:0] limit;

   // Accept threshold is Neff-1; thresh == 0 behaves like thresh == 1.
   // Using >= rather than == lets a lowered thresh accept on the next
   // differing edge instead of counting up to a wrap.
   always_comb begin
      limit = '0;
      if (thresh != '0) begin
         limit = thresh - CNT_W'(1);
      end
   end

   always_comb begin
      level_nxt = level;
      rise_nxt  = '0;
      fall_nxt  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (din[i] != level[i]) begin
            if (cnt[i] >= limit) begin
               level_nxt[i] = din[i];
               rise_nxt[i]  = din[i];
               fall_nxt[i]  = ~din[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= RST_VAL;
         rise  <= '0;
         fall  <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         level <= level_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//
// Directed bench for debounce_edge with WIDTH=4, CNT_W=16, RST_VAL=0.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. reflecting the edge just taken.
// -----------------------------------------------------------------------------
module tb_debounce_edge;

   localparam int unsigned W = 4;
   localparam int unsigned C = 16;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  din;
   logic [C-1:0]  thresh;
   logic [W-1:0]  level;
   logic [W-1:0]  rise;
   logic [W-1:0]  fall;

   int checks = 0;
   int errors = 0;

   debounce_edge #(
      .WIDTH   (W),
      .CNT_W   (C),
      .RST_VAL (4'b0000)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din),
      .thresh (thresh),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [W-1:0] el,
                       input logic [W-1:0] er, input logic [W-1:0] ef);
      check({tag, ".level"}, level, el);
      check({tag, ".rise"},  rise,  er);
      check({tag, ".fall"},  fall,  ef);
   endtask

   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] v;

      // Reset with all inputs high: outputs held at RST_VAL / zero
      rst_n  = 1'b0;
      din    = 4'hF;
      thresh = 16'd4;
      step();
      step();
      chk3("reset", 4'h0, 4'h0, 4'h0);
      din   = 4'h0;
      rst_n = 1'b1;
      step();
      step();
      chk3("post_reset", 4'h0, 4'h0, 4'h0);

      // Clean step, thresh=4: level rises on the 4th edge
      din = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk3("clean_wait", 4'h0, 4'h0, 4'h0);
      end
      step();
      chk3("clean_rise", 4'b0001, 4'b0001, 4'h0);
      step();
      chk3("clean_hold", 4'b0001, 4'h0, 4'h0);
      din = 4'b0000;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk3("clean_fwait", 4'b0001, 4'h0, 4'h0);
      end
      step();
      chk3("clean_fall", 4'h0, 4'h0, 4'b0001);

      // Glitch: 3 high, 1 low, then 4 high
      din = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk3("glitch_burst1", 4'h0, 4'h0, 4'h0);
      end
      din = 4'b0000;
      step();
      chk3("glitch_gap", 4'h0, 4'h0, 4'h0);
      din = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk3("glitch_burst2", 4'h0, 4'h0, 4'h0);
      end
      step();
      chk3("glitch_rise", 4'b0001, 4'b0001, 4'h0);
      din = 4'b0000;
      for (int k = 1; k <= 4; k++) step();
      chk3("glitch_restore", 4'h0, 4'h0, 4'b0001);

      // thresh=0 and thresh=1: din[1] toggling every cycle, level follows by one edge
      for (int t = 0; t <= 1; t++) begin
         thresh = C'(t);
         prev   = 4'h0;
         for (int k = 0; k < 6; k++) begin
            v   = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            din = v;
            step();
            chk3(t == 0 ? "toggle_t0" : "toggle_t1", v, v & ~prev, ~v & prev);
            check("toggle_excl", rise & fall, 4'h0);
            prev = v;
         end
      end

      // Threshold lowered mid-count: accept on the next differing edge
      thresh = 16'd10;
      din    = 4'b0100;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk3("thr_count", 4'h0, 4'h0, 4'h0);
      end
      thresh = 16'd3;
      step();
      chk3("thr_accept", 4'b0100, 4'b0100, 4'h0);
      din = 4'b0000;
      step();
      step();
      chk3("thr_fwait", 4'b0100, 4'h0, 4'h0);
      step();
      chk3("thr_fall", 4'h0, 4'h0, 4'b0100);

      // Multi-channel, thresh=5: bits 0 and 2 together on the 5th edge
      thresh = 16'd5;
      din    = 4'b0101;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk3("multi_wait", 4'h0, 4'h0, 4'h0);
      end
      step();
      chk3("multi_rise", 4'b0101, 4'b0101, 4'h0);
      din = 4'b0000;
      for (int k = 1; k <= 5; k++) step();
      chk3("multi_fall", 4'h0, 4'h0, 4'b0101);

      // Same step with reset pulsed over edge 3: count discarded, restarts after release
      din = 4'b0101;
      step();
      step();
      rst_n = 1'b0;
      step();
      chk3("midreset", 4'h0, 4'h0, 4'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk3("restart_wait", 4'h0, 4'h0, 4'h0);
      end
      step();
      chk3("restart_rise", 4'b0101, 4'b0101, 4'h0);
      step();
      chk3("restart_hold", 4'b0101, 4'h0, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
